bcd4digit_to_bin: RTL and testbench

// - Converts a 4-digit packed BCD number (A thousands .. D units) to a BIN_W-bit binary value.
// - Inverse of the binary-to-BCD display path. Feeds switch/keypad BCD entry back into

---
 rtl/bcd4digit_to_bin.sv | 111 +++++++++++
 tb/tb_bcd4digit_to_bin.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd4digit_to_bin.sv
// rtl/bcd4digit_to_bin.sv - 4-digit packed BCD to binary, sequential reverse double-dabble (optional BCD_ERR_EN digit check)
module bcd4digit_to_bin #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic [3:0]       C,
    input  logic [3:0]       D,
    input  logic             start,
    output logic [BIN_W-1:0] value,
    output logic             busy,
    output logic             done
`ifdef BCD_ERR_EN
   ,output logic             err
`endif
);

    // BCD field sits above the binary field; bits migrate down into the binary field one per shift
    localparam int SR_W  = BIN_W + 16;
    localparam int CNT_W = $clog2(BIN_W);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           r_state;
    logic [SR_W-1:0]  r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic [SR_W-1:0]  w_sr_next;

    // Shift right one place, then pull every BCD nibble that reads >= 8 back down by 3
    function automatic logic [SR_W-1:0] adj(input logic [SR_W-1:0] s);
        logic [SR_W-1:0] r;
        r = s;
        for (int n = 0; n < 4; n++) begin
            if (r[BIN_W+4*n +: 4] >= 4'd8) begin
                r[BIN_W+4*n +: 4] = r[BIN_W+4*n +: 4] - 4'd3;
            end
        end
        return r;
    endfunction

    // Next shift-register value for the current iteration
    always_comb begin
        w_sr_next = adj(r_sr >> 1);
    end

`ifdef BCD_ERR_EN
    logic w_dig_bad;
    logic r_err_pend;

    // Any digit outside 0..9 in the presented word
    always_comb begin
        w_dig_bad = (A > 4'd9) || (B > 4'd9) || (C > 4'd9) || (D > 4'd9);
    end
`endif

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            value   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef BCD_ERR_EN
            err        <= 1'b0;
            r_err_pend <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sr    <= {A, B, C, D, {BIN_W{1'b0}}};
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
`ifdef BCD_ERR_EN
                        r_err_pend <= w_dig_bad;
`endif
                    end
                end
                S_SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(BIN_W - 1)) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
`ifdef BCD_ERR_EN
                        err   <= r_err_pend;
                        value <= r_err_pend ? '0 : w_sr_next[BIN_W-1:0];
`else
                        value <= w_sr_next[BIN_W-1:0];
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd4digit_to_bin.sv
// tb/tb_bcd4digit_to_bin.sv - table-driven scoreboard bench for bcd4digit_to_bin
module tb_bcd4digit_to_bin;

    localparam int BIN_W = 14;

    logic             clk;
    logic             rst;
    logic [3:0]       A, B, C, D;
    logic             start;
    logic [BIN_W-1:0] value;
    logic             busy;
    logic             done;
`ifdef BCD_ERR_EN
    logic             err;
`endif

    bcd4digit_to_bin #(.BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done)
`ifdef BCD_ERR_EN
       ,.err   (err)
`endif
    );

    typedef struct {
        int   val;
        logic err;
    } exp_t;

    typedef struct {
        logic [3:0] a, b, c, d;
        int         val;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;
    exp_t q[$];
    vec_t vecs[10];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Scoreboard: compare each done pulse against the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("value", int'(value), e.val);
`ifdef BCD_ERR_EN
                    chk("err", int'(err), int'(e.err));
`endif
                end
                if (prev_done) chk("done_width", 2, 1);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic run_one(input logic [3:0] a, b, c, d, input exp_t e);
        int nb;
        @(negedge clk);
        A = a; B = b; C = c; D = d;
        start = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 4'($urandom_range(0, 9)); B = 4'($urandom_range(0, 9));
        C = 4'($urandom_range(0, 9)); D = 4'($urandom_range(0, 9));
        nb = 0;
        @(negedge clk);
        while (busy && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        chk("busy_cycles", nb, BIN_W);
        chk("done_at_end", int'(done), 1);
        @(negedge clk);
        chk("done_cleared", int'(done), 0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        exp_t e;
        int   n, base_cnt;
        int   t[3];

        vecs[0] = '{4'd0, 4'd3, 4'd5, 4'd1, 351};
        vecs[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 9999};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 0};
        vecs[3] = '{4'd8, 4'd0, 4'd0, 4'd0, 8000};
        vecs[4] = '{4'd0, 4'd9, 4'd9, 4'd9, 999};
        vecs[5] = '{4'd1, 4'd0, 4'd0, 4'd0, 1000};
        vecs[6] = '{4'd5, 4'd5, 4'd5, 4'd5, 5555};
        vecs[7] = '{4'd0, 4'd0, 4'd0, 4'd1, 1};
        vecs[8] = '{4'd7, 4'd0, 4'd8, 4'd9, 7089};
        vecs[9] = '{4'd3, 4'd1, 4'd4, 4'd2, 3142};

        rst = 1'b1; start = 1'b0;
        A = 4'd0; B = 4'd0; C = 4'd0; D = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_value", int'(value), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
`ifdef BCD_ERR_EN
        chk("reset_err", int'(err), 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            e.val = vecs[i].val; e.err = 1'b0;
            run_one(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, e);
        end

        // start pulsed mid-conversion with new digits must be ignored
        base_cnt = done_cnt;
        @(negedge clk);
        A = 4'd1; B = 4'd0; C = 4'd2; D = 4'd3; start = 1'b1;
        e.val = 1023; e.err = 1'b0; q.push_back(e);
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        A = 4'd9; B = 4'd8; C = 4'd7; D = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        repeat (30) @(negedge clk);
        chk("ignored_start_dones", done_cnt - base_cnt, 1);

        // reset mid-conversion discards it
        @(negedge clk);
        A = 4'd4; B = 4'd5; C = 4'd6; D = 4'd7; start = 1'b1;
        e.val = 4567; q.push_back(e);
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        q.delete();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_value", int'(value), 0);
        @(negedge clk);
        rst = 1'b0;
        e.val = 4567;
        run_one(4'd4, 4'd5, 4'd6, 4'd7, e);

        // start held high: one result per BIN_W+1 clocks
        e.val = 2015;
        for (int i = 0; i < 3; i++) q.push_back(e);
        @(negedge clk);
        A = 4'd2; B = 4'd0; C = 4'd1; D = 4'd5; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_done(n);
            t[i] = cyc;
            if (i == 2) start = 1'b0;
        end
        chk("hold_period_1", t[1] - t[0], BIN_W + 1);
        chk("hold_period_2", t[2] - t[1], BIN_W + 1);
        repeat (20) @(negedge clk);
        chk("hold_queue_drained", q.size(), 0);

`ifdef BCD_ERR_EN
        e.val = 0; e.err = 1'b1;
        run_one(4'd1, 4'd2, 4'd3, 4'hA, e);
        e.val = 1234; e.err = 1'b0;
        run_one(4'd1, 4'd2, 4'd3, 4'd4, e);
`endif

        repeat (3) @(negedge clk);
        chk("final_queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
